// File: rtl/dmem_responder.sv
// Multi-cycle byte-addressed data memory behind a valid/ready request port.
// A request is captured in IDLE, held for WAIT_CYCLES wait states, then answered with a one-cycle response pulse.
module dmem_responder #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_re,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int WORDS = 2**(DM_ADDRESS-2);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic                  re;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic [2:0]            funct3;
  } req_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  req_t            r_req;
  logic [3:0][7:0] r_mem [WORDS];

  req_t                  w_in;
  req_t                  w_req;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_err;
  logic [1:0]            w_size;
  logic [1:0]            w_lane;
  logic [DM_ADDRESS-3:0] w_idx;
  logic [3:0][7:0]       w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [3:0]            w_be;
  logic [3:0][7:0]       w_wword;
  logic [31:0]           w_rdata;

  assign w_in      = '{we: req_we, re: req_re, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
  assign req_ready = (r_state == IDLE);
  assign w_accept  = (r_state == IDLE) && req_valid && (req_we || req_re);
  // With no wait states the access happens on the acceptance edge itself, straight from the port.
  assign w_commit  = reset && ((WAIT_CYCLES == 0) ? w_accept : (r_state == BUSY && r_cnt == 4'd1));
  assign w_req     = (r_state == IDLE) ? w_in : r_req;

  assign w_size = w_req.funct3[1:0];
  assign w_lane = w_req.addr[1:0];
  assign w_idx  = w_req.addr[DM_ADDRESS-1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[w_lane];
  assign w_half = w_req.addr[1] ? w_word[3:2] : w_word[1:0];

  always_comb begin
    w_err = (w_req.we && w_req.re)
         || (w_req.re && (w_req.funct3 == 3'd3 || w_req.funct3 == 3'd6 || w_req.funct3 == 3'd7))
         || (w_req.we && w_req.funct3 > 3'd2)
         || (w_size == 2'd1 && w_req.addr[0])
         || (w_size == 2'd2 && w_req.addr[1:0] != 2'd0);

    case (w_req.funct3)
      3'd0:    w_rdata = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_rdata = {24'd0, w_byte};
      3'd1:    w_rdata = {{16{w_half[15]}}, w_half};
      3'd5:    w_rdata = {16'd0, w_half};
      3'd2:    w_rdata = w_word;
      default: w_rdata = 32'd0;
    endcase
    if (w_err || w_req.we) w_rdata = 32'd0;

    case (w_size)
      2'd0:    begin w_be = 4'b0001 << w_lane; w_wword = {4{w_req.wdata[7:0]}}; end
      2'd1:    begin w_be = w_req.addr[1] ? 4'b1100 : 4'b0011; w_wword = {2{w_req.wdata[15:0]}}; end
      default: begin w_be = 4'b1111; w_wword = w_req.wdata; end
    endcase
  end

  // Storage has no reset; only lanes selected by the access size are written.
  always_ff @(posedge clk) begin
    if (w_commit && w_req.we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][i] <= w_wword[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_req     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (w_commit) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= w_rdata;
        rsp_err   <= w_err;
      end
      case (r_state)
        IDLE: if (w_accept) begin
          r_req   <= w_in;
          r_cnt   <= 4'(WAIT_CYCLES);
          r_state <= (WAIT_CYCLES == 0) ? RESP : BUSY;
        end
        BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance (index 0) and a WAIT_CYCLES=0 instance (index 1),
// checked every cycle against a timeline model of the response schedule and a byte-array memory.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_we    [2];
  logic        req_re    [2];
  logic [8:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [2:0]  req_f3    [2];
  logic        rdy [2];
  logic        rv  [2];
  logic        rerr[2];
  logic [31:0] rd  [2];

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid[0]), .req_ready(rdy[0]),
    .req_we(req_we[0]), .req_re(req_re[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_funct3(req_f3[0]), .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(rerr[0]));

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid[1]), .req_ready(rdy[1]),
    .req_we(req_we[1]), .req_re(req_re[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_funct3(req_f3[1]), .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(rerr[1]));

  int vecs = 0;
  int errs = 0;

  function automatic int wc(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0]  mm [2][512];
  int          e = 0;
  int          free_at [2] = '{0, 0};
  bit          pend    [2] = '{0, 0};
  int          due     [2];
  bit          p_we [2], p_re [2];
  logic [8:0]  p_a  [2];
  logic [31:0] p_wd [2];
  logic [2:0]  p_f3 [2];
  bit          x_valid [2] = '{0, 0};
  bit          x_err   [2] = '{0, 0};
  bit          x_ready [2] = '{1, 1};
  logic [31:0] x_rdata [2] = '{0, 0};
  bit          acc_t;

  task automatic model_access(int k, bit we, bit re, logic [8:0] a, logic [31:0] wd, logic [2:0] f3,
                              output logic [31:0] r, output bit er);
    int n;
    logic [31:0] v;
    n  = 1 << f3[1:0];
    er = (we && re) || (re && (f3 == 3 || f3 >= 6)) || (we && f3 > 2)
      || (f3[1:0] == 1 && a[0]) || (f3[1:0] == 2 && a[1:0] != 0);
    r = 0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) mm[k][int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[k][int'(a) + i]) << (8*i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        r = v;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        pend[k] = 0; x_valid[k] = 0; x_rdata[k] = 0; x_err[k] = 0;
        free_at[k] = e; x_ready[k] = 1;
      end
    end else begin
      e++;
      for (int k = 0; k < 2; k++) begin
        x_valid[k] = 0;
        if (pend[k] && due[k] == e) begin
          model_access(k, p_we[k], p_re[k], p_a[k], p_wd[k], p_f3[k], x_rdata[k], x_err[k]);
          x_valid[k] = 1;
          pend[k] = 0;
        end
        acc_t = (e >= free_at[k]) && req_valid[k] && (req_we[k] || req_re[k]);
        if (acc_t) begin
          free_at[k] = e + wc(k) + 2;
          if (wc(k) == 0) begin
            model_access(k, req_we[k], req_re[k], req_addr[k], req_wdata[k], req_f3[k], x_rdata[k], x_err[k]);
            x_valid[k] = 1;
          end else begin
            pend[k] = 1; due[k] = e + wc(k);
            p_we[k] = req_we[k]; p_re[k] = req_re[k]; p_a[k] = req_addr[k];
            p_wd[k] = req_wdata[k]; p_f3[k] = req_f3[k];
          end
        end
        x_ready[k] = (e + 1 >= free_at[k]);
      end
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("req_ready", k, 32'(rdy[k]), 32'(x_ready[k]));
      chk("rsp_valid", k, 32'(rv[k]), 32'(x_valid[k]));
      chk("rsp_rdata", k, rd[k], x_rdata[k]);
      chk("rsp_err", k, 32'(rerr[k]), 32'(x_err[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(int k, bit we, bit re, logic [8:0] a, logic [31:0] wd, logic [2:0] f3, output int acc_e);
    int n = 0;
    @(negedge clk);
    while (!rdy[k] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      errs++;
      $display("FAIL ready_timeout[%0d]: req_ready stayed 0 for %0d cycles, need 1", k, n);
    end
    req_valid[k] = 1; req_we[k] = we; req_re[k] = re;
    req_addr[k] = a; req_wdata[k] = wd; req_f3[k] = f3;
    @(posedge clk);
    #1;
    acc_e = e;
    req_valid[k] = 0; req_we[k] = 0; req_re[k] = 0;
  endtask

  task automatic wait_rsp(int k, int lat, logic [31:0] xr, bit xe);
    int n = 0;
    int low = 0;
    do begin
      @(negedge clk);
      n++;
      if (rdy[k]) low++;
    end while (!rv[k] && n < 20);
    chk("latency", k, 32'(n), 32'(lat));
    chk("ready_low", k, 32'(low), 32'd0);
    chk("lit_rdata", k, rd[k], xr);
    chk("lit_err", k, 32'(rerr[k]), 32'(xe));
    chk("model_rdata", k, x_rdata[k], xr);
  endtask

  task automatic txn(int k, bit we, bit re, logic [8:0] a, logic [31:0] wd, logic [2:0] f3,
                     logic [31:0] xr, bit xe);
    int ae;
    issue(k, we, re, a, wd, f3, ae);
    wait_rsp(k, wc(k) + 1, xr, xe);
  endtask

  initial begin
    int e1, e2;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 0; req_we[k] = 0; req_re[k] = 0;
      req_addr[k] = 0; req_wdata[k] = 0; req_f3[k] = 0;
    end
    #1 rst_n = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, 32'(rdy[k]), 32'd1);
      chk("rst_valid", k, 32'(rv[k]), 32'd0);
      chk("rst_rdata", k, rd[k], 32'd0);
      chk("rst_err", k, 32'(rerr[k]), 32'd0);
    end
    @(negedge clk);
    #2 rst_n = 1;

    // WAIT_CYCLES=2 instance
    txn(0, 1, 0, 9'h010, 32'hDEADBEEF, 3'd2, 32'h0, 0);
    txn(0, 0, 1, 9'h010, 32'h0,        3'd2, 32'hDEADBEEF, 0);
    txn(0, 1, 0, 9'h020, 32'h11223344, 3'd2, 32'h0, 0);
    txn(0, 1, 0, 9'h021, 32'h00000080, 3'd0, 32'h0, 0);
    txn(0, 0, 1, 9'h021, 32'h0,        3'd0, 32'hFFFFFF80, 0);
    txn(0, 0, 1, 9'h021, 32'h0,        3'd4, 32'h00000080, 0);
    txn(0, 0, 1, 9'h020, 32'h0,        3'd2, 32'h11228044, 0);
    txn(0, 1, 0, 9'h030, 32'h0,        3'd2, 32'h0, 0);
    txn(0, 1, 0, 9'h032, 32'h0000ABCD, 3'd1, 32'h0, 0);
    txn(0, 0, 1, 9'h032, 32'h0,        3'd1, 32'hFFFFABCD, 0);
    txn(0, 0, 1, 9'h032, 32'h0,        3'd5, 32'h0000ABCD, 0);
    txn(0, 0, 1, 9'h030, 32'h0,        3'd2, 32'hABCD0000, 0);
    txn(0, 0, 1, 9'h013, 32'h0,        3'd2, 32'h0, 1);
    txn(0, 1, 0, 9'h040, 32'h55667788, 3'd2, 32'h0, 0);
    txn(0, 1, 0, 9'h041, 32'h0000FFFF, 3'd1, 32'h0, 1);
    txn(0, 0, 1, 9'h040, 32'h0,        3'd2, 32'h55667788, 0);
    txn(0, 1, 1, 9'h060, 32'h0,        3'd2, 32'h0, 1);
    txn(0, 0, 1, 9'h010, 32'h0,        3'd3, 32'h0, 1);
    txn(0, 1, 0, 9'h010, 32'h0,        3'd4, 32'h0, 1);
    txn(0, 0, 1, 9'h010, 32'h0,        3'd2, 32'hDEADBEEF, 0);

    // Reset during BUSY discards the pending store
    txn(0, 1, 0, 9'h050, 32'h0, 3'd2, 32'h0, 0);
    issue(0, 1, 0, 9'h050, 32'h12345678, 3'd2, e1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("busy_rst_valid", 0, 32'(rv[0]), 32'd0);
    chk("busy_rst_rdata", 0, rd[0], 32'd0);
    chk("busy_rst_err", 0, 32'(rerr[0]), 32'd0);
    chk("busy_rst_ready", 0, 32'(rdy[0]), 32'd1);
    #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 0, 32'(rv[0]), 32'd0);
    end
    txn(0, 0, 1, 9'h050, 32'h0, 3'd2, 32'h0, 0);

    // WAIT_CYCLES=0 instance, back-to-back at the earliest legal edges
    issue(1, 1, 0, 9'h100, 32'hCAFEF00D, 3'd2, e1);
    wait_rsp(1, 1, 32'h0, 0);
    issue(1, 0, 1, 9'h100, 32'h0, 3'd2, e2);
    wait_rsp(1, 1, 32'hCAFEF00D, 0);
    chk("accept_gap", 1, 32'(e2 - e1), 32'd2);
    txn(1, 0, 1, 9'h102, 32'h0, 3'd1, 32'hFFFFCAFE, 0);
    txn(1, 0, 1, 9'h101, 32'h0, 3'd4, 32'h000000F0, 0);
    txn(1, 0, 1, 9'h102, 32'h0, 3'd2, 32'h0, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
